uart_led_ctrl: RTL and testbench



---
 rtl/uart_led_ctrl.sv | 94 +++++++++
 tb/tb_uart_led_ctrl.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/uart_led_ctrl.sv
// Button-driven LED pattern controller: edge-detected presses rotate a
// 4-bit pattern and pick which of three colour buses displays it.
module uart_led_ctrl #(
  parameter logic [3:0] RESET_PATTERN = 4'b0001
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] button,
  output logic [3:0] rled,
  output logic [3:0] gled,
  output logic [3:0] bled
);

  localparam logic [1:0] BLUE  = 2'd0;
  localparam logic [1:0] RED   = 2'd1;
  localparam logic [1:0] GREEN = 2'd2;

  logic [3:0] b_d1;
  logic [3:0] b_d2;
  logic [3:0] rise;
  logic [3:0] pattern;
  logic [3:0] pat_nx;
  logic [1:0] colour;
  logic [1:0] col_fwd;
  logic [1:0] col_bwd;
  logic [1:0] col_nx;

  assign rise = b_d1 & ~b_d2;

  always_comb begin
    pat_nx = pattern;
    unique case (1'b1)
      rise[0] & ~rise[3]: pat_nx = {pattern[2:0], pattern[3]};
      rise[3] & ~rise[0]: pat_nx = {pattern[0], pattern[3:1]};
      default: ;
    endcase
  end

  always_comb begin
    col_fwd = BLUE;
    col_bwd = BLUE;
    case (colour)
      BLUE: begin
        col_fwd = RED;
        col_bwd = GREEN;
      end
      RED: begin
        col_fwd = GREEN;
        col_bwd = BLUE;
      end
      GREEN: begin
        col_fwd = BLUE;
        col_bwd = RED;
      end
      default: ;
    endcase
  end

  always_comb begin
    col_nx = colour;
    unique case (1'b1)
      rise[2] & ~rise[1]: col_nx = col_fwd;
      rise[1] & ~rise[2]: col_nx = col_bwd;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      b_d1    <= '0;
      b_d2    <= '0;
      pattern <= RESET_PATTERN;
      colour  <= BLUE;
    end else begin
      b_d1    <= button;
      b_d2    <= b_d1;
      pattern <= pat_nx;
      colour  <= col_nx;
    end
  end

  always_comb begin
    rled = '0;
    gled = '0;
    bled = '0;
    case (colour)
      BLUE:    bled = pattern;
      RED:     rled = pattern;
      GREEN:   gled = pattern;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_uart_led_ctrl.sv
// Bench for uart_led_ctrl: directed presses with literal expectations,
// then random button traffic against a position/colour-index model.
module tb_uart_led_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] button = 4'b0000;
  logic [3:0] rled;
  logic [3:0] gled;
  logic [3:0] bled;

  int compared = 0;
  int mismatched = 0;
  bit chk_en = 1'b0;

  // model: lit bit position and colour index (0 blue, 1 red, 2 green)
  int pos = 0;
  int col = 0;
  logic [3:0] last = 4'b0000;
  logic [3:0] pend = 4'b0000;

  uart_led_ctrl #(.RESET_PATTERN(4'b0001)) dut (
    .clk(clk),
    .rst(rst),
    .button(button),
    .rled(rled),
    .gled(gled),
    .bled(bled)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pos  <= 0;
      col  <= 0;
      last <= 4'b0000;
      pend <= 4'b0000;
    end else begin
      if (pend[0] && !pend[3]) pos <= (pos + 1) % 4;
      if (pend[3] && !pend[0]) pos <= (pos + 3) % 4;
      if (pend[2] && !pend[1]) col <= (col + 1) % 3;
      if (pend[1] && !pend[2]) col <= (col + 2) % 3;
      pend <= button & ~last;
      last <= button;
    end
  end

  task automatic check(string nm, logic [3:0] got, logic [3:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %b expected %b at %0t", nm, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [3:0] ep;
    if (chk_en) begin
      ep = 4'(1 << pos);
      check("model_rled", rled, (col == 1) ? ep : 4'b0000);
      check("model_gled", gled, (col == 2) ? ep : 4'b0000);
      check("model_bled", bled, (col == 0) ? ep : 4'b0000);
    end
  end

  task automatic pulse(logic [3:0] b);
    button = b;
    @(negedge clk);
    button = 4'b0000;
    @(negedge clk);
    #1;
  endtask

  task automatic leds(string nm, logic [3:0] r, logic [3:0] g, logic [3:0] b);
    check({nm, "_r"}, rled, r);
    check({nm, "_g"}, gled, g);
    check({nm, "_b"}, bled, b);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    #1;
    leds("reset", 4'b0000, 4'b0000, 4'b0001);

    pulse(4'b0001);
    leds("left1", 4'b0000, 4'b0000, 4'b0010);
    pulse(4'b1000);
    leds("right1", 4'b0000, 4'b0000, 4'b0001);
    pulse(4'b0100);
    leds("next1", 4'b0001, 4'b0000, 4'b0000);
    pulse(4'b0010);
    leds("prev1", 4'b0000, 4'b0000, 4'b0001);

    repeat (3) pulse(4'b0001);
    check("left_x3", bled, 4'b1000);
    pulse(4'b0001);
    check("left_wrap", bled, 4'b0001);
    pulse(4'b1000);
    check("right_wrap", bled, 4'b1000);
    pulse(4'b0001);
    repeat (3) pulse(4'b0100);
    leds("next_x3", 4'b0000, 4'b0000, 4'b0001);
    pulse(4'b0010);
    leds("prev_wrap", 4'b0000, 4'b0001, 4'b0000);
    pulse(4'b0100);

    button = 4'b0001;
    repeat (10) @(negedge clk);
    button = 4'b0000;
    @(negedge clk);
    #1;
    leds("hold", 4'b0000, 4'b0000, 4'b0010);
    pulse(4'b1001);
    leds("both_rot", 4'b0000, 4'b0000, 4'b0010);
    pulse(4'b1000);
    pulse(4'b0101);
    leds("rot_col", 4'b0010, 4'b0000, 4'b0000);
    pulse(4'b0110);
    leds("both_col", 4'b0010, 4'b0000, 4'b0000);

    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      button = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
    end
    button = 4'b0000;
    repeat (3) @(negedge clk);

    pulse(4'b0001);
    pulse(4'b0100);
    button = 4'b0001;
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    leds("async_rst", 4'b0000, 4'b0000, 4'b0001);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    leds("press_after_rst", 4'b0000, 4'b0000, 4'b0010);
    button = 4'b0000;
    repeat (3) @(negedge clk);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
